// File: rtl/prio_arb_pkg.sv
// Shared definitions for the prio_arb_n arbiter slice.
//   MODE_FIXED / MODE_RR : encodings of the arbiter's mode input
//   state_t              : arbiter FSM state (IDLE, GRANT)
//   wrap_add             : (a + b) mod n for operands already in 0..n-1
package prio_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Both operands are below n, so a single conditional subtract is enough
    // and no divider is inferred.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// N-input priority encoder, highest set index wins.
// Generalisation of the classic 4-to-2 encoder.
//   req : request vector
//   idx : index of the highest set bit (0 when none set)
//   any : at least one bit of req is set
module prio_enc_n #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan where later hits overwrite earlier ones, so the
    // highest set bit is the one that survives.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arb_n.sv
// Registered N-way priority arbiter with fixed / round-robin modes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : request vector, bit i = requester i wants service
//   mode        : 0 fixed priority (highest index), 1 round-robin
//   gnt_ready   : consumer takes the presented grant this cycle
//   gnt_valid   : a grant is presented
//   gnt_idx     : granted index (keeps its value after returning to idle)
//   gnt_onehot  : one-hot of gnt_idx, zero while gnt_valid is low
//   last_idx    : last accepted index, the round-robin pointer
//   dbg_state   : current FSM state (0 IDLE, 1 GRANT)
//
// Handshake: a grant transfers on a rising edge where gnt_valid and
// gnt_ready are both high. While gnt_valid is high and gnt_ready low, the
// grant is held unchanged no matter what req does. gnt_ready is ignored
// while gnt_valid is low.
module prio_arb_n
    import prio_arb_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] last_idx,
    output logic         dbg_state
);

    state_t       state;
    logic [N-1:0] search_req;
    logic [N-1:0] rot_req;
    logic [N-1:0] enc_in;
    logic [W-1:0] enc_idx;
    logic         enc_any;
    logic [W-1:0] win_idx;

    // gnt_onehot is zero in IDLE and marks the grant being accepted in
    // GRANT, so masking with it gives the back-to-back exclusion for free.
    assign search_req = req & ~gnt_onehot;

    // Rotate so that bit j holds requester (j + last_idx) mod N: the MSB is
    // then (last_idx - 1) mod N and bit 0 is last_idx itself, which makes
    // the plain MSB-first encoder implement round-robin order.
    always_comb begin
        rot_req = '0;
        for (int j = 0; j < N; j++) begin
            rot_req[j] = search_req[wrap_add(j, int'(last_idx), N)];
        end
    end

    assign enc_in = (mode == MODE_RR) ? rot_req : search_req;

    prio_enc_n #(.N(N)) u_enc (
        .req (enc_in),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        win_idx = enc_idx;
        if (mode == MODE_RR) begin
            win_idx = W'(wrap_add(int'(enc_idx), int'(last_idx), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            last_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_any) begin
                        state      <= GRANT;
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= win_idx;
                        gnt_onehot <= N'(1) << win_idx;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        last_idx <= gnt_idx;
                        if (enc_any) begin
                            gnt_idx    <= win_idx;
                            gnt_onehot <= N'(1) << win_idx;
                        end else begin
                            // Includes the case where only the accepted
                            // requester is still asking: one release cycle.
                            state      <= IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
